phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 127 ++++++++++++
 tb/tb_phase_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: walks FETCH/DECODE/EXEC/MDWAIT/MEM/WB
// and emits Moore datapath strobes, with a bounded multdiv wait and a halt state.
module phase_sequencer #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_md,
  input  logic        writes_rd,
  input  logic        is_halt,
  input  logic        md_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic        rf_we,
  output logic        dmem_we,
  output logic        md_start,
  output logic        md_timeout,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MDWAIT = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             abort_q, abort_d;
  logic [15:0]      count_q, count_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    abort_d = abort_q;
    count_d = count_q;
    case (state_q)
      S_FETCH:  if (run) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_md) begin
          state_d = S_MDWAIT;
          wait_d  = '0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (is_load | is_store) ? S_MEM : S_WB;
      // A result arriving on the final allowed cycle still counts as success.
      S_MDWAIT: begin
        if (md_ready) begin
          state_d = S_WB;
        end else if (wait_q == CNT_LAST) begin
          state_d = S_WB;
          abort_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_MEM:    state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        abort_d = 1'b0;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_FETCH;
        abort_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      abort_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  // Strobes are gated by reset so nothing fires before the first edge with reset low.
  always_comb begin
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    rf_we      = 1'b0;
    dmem_we    = 1'b0;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH:  ir_en    = run;
        S_DECODE: md_start = is_md & ~is_halt;
        S_MEM:    dmem_we  = is_store;
        S_WB: begin
          pc_en      = 1'b1;
          rf_we      = writes_rd & ~abort_q;
          md_timeout = abort_q;
        end
        S_HALT:   halted   = 1'b1;
        default:  ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scenario bench for phase_sequencer: each instruction's expected retirement
// record is queued when issued and compared when its WB is observed.
module tb_phase_sequencer;

  localparam int T = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, is_md = 1'b0, writes_rd = 1'b0, is_halt = 1'b0;
  logic        md_ready = 1'b0;
  logic        ir_en, pc_en, rf_we, dmem_we, md_start, md_timeout, halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  phase_sequencer #(.MD_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .run(run),
    .is_load(is_load), .is_store(is_store), .is_md(is_md),
    .writes_rd(writes_rd), .is_halt(is_halt), .md_ready(md_ready),
    .ir_en(ir_en), .pc_en(pc_en), .rf_we(rf_we), .dmem_we(dmem_we),
    .md_start(md_start), .md_timeout(md_timeout), .halted(halted),
    .state(state), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          lat;
    bit          rf;
    bit          dm;
    bit          mdto;
    int          mdw;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] model_cnt = 16'd0;

  // Observations gathered by exec_instr
  int          obs_lat, obs_mdw, obs_mdstart, obs_rfcnt, obs_excl, obs_len;
  bit          obs_rf, obs_dm, obs_mdto, obs_done;
  longint      obs_code;

  task automatic set_cls(input bit ld, input bit st, input bit md, input bit wr, input bit ht);
    is_load = ld; is_store = st; is_md = md; writes_rd = wr; is_halt = ht;
  endtask

  // Push the reference record for one instruction; ready_at is the MDWAIT index
  // at which md_ready rises (0 = never).
  task automatic push_exp(input bit ld, input bit st, input bit md, input bit wr, input int ready_at);
    exp_t e;
    int   n;
    if (md) begin
      n = (ready_at >= 1 && ready_at <= T) ? ready_at : T;
      e.lat  = 2 + n + 1;
      e.mdw  = n;
      e.mdto = !(ready_at >= 1 && ready_at <= T);
    end else begin
      e.lat  = (ld || st) ? 5 : 4;
      e.mdw  = 0;
      e.mdto = 1'b0;
    end
    e.rf = wr && !e.mdto;
    e.dm = st;
    model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
    e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  // Called just after a negedge with the DUT in FETCH; returns at the
  // negedge of the FETCH cycle following WB.
  task automatic exec_instr(input bit ld, input bit st, input bit md, input bit wr, input int ready_at);
    bit wb_seen = 1'b0;
    obs_lat = 0; obs_mdw = 0; obs_mdstart = 0; obs_rfcnt = 0; obs_excl = 0;
    obs_len = 0; obs_code = 0; obs_rf = 0; obs_dm = 0; obs_mdto = 0; obs_done = 0;
    run = 1'b1;
    md_ready = 1'b0;
    set_cls(ld, st, md, wr, 1'b0);
    for (int k = 0; k < 200; k++) begin
      #1;
      obs_len++;
      obs_code = obs_code * 8 + longint'(state);
      if (wb_seen) begin
        obs_done = 1'b1;
        break;
      end
      if (int'(ir_en) + int'(dmem_we) + int'(rf_we) + int'(md_start) > 1) obs_excl++;
      if (md_start) obs_mdstart++;
      if (rf_we) obs_rfcnt++;
      if (state == 3'd3) begin
        obs_mdw++;
        md_ready = (obs_mdw == ready_at);
      end else begin
        md_ready = 1'b0;
      end
      if (state == 3'd4) obs_dm = dmem_we;
      if (state == 3'd5) begin
        obs_lat = obs_len; obs_rf = rf_we; obs_mdto = md_timeout; wb_seen = 1'b1;
      end
      @(negedge clock);
    end
    md_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_cnt = 16'd0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0; run = 1'b1;
    set_cls(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clock); @(negedge clock);
    #1;
    n_cmp++;
    if ({state, instr_count} !== {3'd0, 16'd0}) begin
      n_err++; $display("FAIL reset_state: got state=%0d cnt=%0d want 0/0", state, instr_count);
    end
    n_cmp++;
    if ({ir_en, pc_en, rf_we, dmem_we, md_start, md_timeout, halted} !== 7'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000000",
                        {ir_en, pc_en, rf_we, dmem_we, md_start, md_timeout, halted});
    end
    @(negedge clock);
    reset = 1'b1; run = 1'b0;
    #1;
    n_cmp++;
    if ({state, ir_en} !== {3'd0, 1'b0}) begin
      n_err++; $display("FAIL release_run0: got state=%0d ir_en=%b want 0/0", state, ir_en);
    end
    run = 1'b1;
    #1;
    n_cmp++;
    if (ir_en !== 1'b1) begin
      n_err++; $display("FAIL first_fetch: got ir_en=%b want 1", ir_en);
    end
    @(negedge clock);
    model_cnt = 16'd0;
    set_cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    do_reset();
  endtask

  // Pops the expected record and compares it with the last exec_instr observations
  task automatic issue(input string nm, input bit ld, input bit st, input bit md, input bit wr, input int ready_at);
    exp_t e;
    push_exp(ld, st, md, wr, ready_at);
    exec_instr(ld, st, md, wr, ready_at);
    e = exp_q.pop_front();
    n_cmp++;
    if (!obs_done) begin
      n_err++; $display("FAIL %s_wb_seen: got none want WB within 200 cycles", nm);
    end
    n_cmp++;
    if (obs_lat !== e.lat) begin
      n_err++; $display("FAIL %s_latency: got %0d want %0d", nm, obs_lat, e.lat);
    end
    n_cmp++;
    if ({obs_rf, obs_dm, obs_mdto} !== {e.rf, e.dm, e.mdto}) begin
      n_err++; $display("FAIL %s_rf_dm_to: got %b%b%b want %b%b%b", nm,
                        obs_rf, obs_dm, obs_mdto, e.rf, e.dm, e.mdto);
    end
    n_cmp++;
    if (obs_mdw !== e.mdw || obs_mdstart !== int'(md)) begin
      n_err++; $display("FAIL %s_mdwait: got mdw=%0d starts=%0d want %0d/%0d", nm,
                        obs_mdw, obs_mdstart, e.mdw, int'(md));
    end
    n_cmp++;
    if (obs_excl !== 0 || obs_rfcnt !== int'(e.rf)) begin
      n_err++; $display("FAIL %s_exclusive: got overlaps=%0d rf_cycles=%0d want 0/%0d", nm,
                        obs_excl, obs_rfcnt, int'(e.rf));
    end
    n_cmp++;
    if (instr_count !== e.cnt) begin
      n_err++; $display("FAIL %s_count: got %0d want %0d", nm, instr_count, e.cnt);
    end
  endtask

  task automatic test_alu();
    issue("alu", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n_cmp++;
    if ({obs_len, obs_code} !== {32'd5, 64'o1250}) begin
      n_err++; $display("FAIL alu_trace: got len=%0d code=%o want 5/1250", obs_len, obs_code);
    end
    issue("alu_nowr", 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_store_load();
    do_reset();
    issue("store", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({obs_len, obs_code} !== {32'd6, 64'o12450}) begin
      n_err++; $display("FAIL store_trace: got len=%0d code=%o want 6/12450", obs_len, obs_code);
    end
    issue("load", 1'b1, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_multdiv();
    issue("md_ready4", 1'b0, 1'b0, 1'b1, 1'b1, 4);
    issue("md_ready1", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    issue("md_timeout", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    issue("alu_after_abort", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    issue("md_ready_last", 1'b0, 1'b0, 1'b1, 1'b1, T);
  endtask

  task automatic test_reset_mid_md();
    int mdw = 0;
    issue("pre_md", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run = 1'b1;
    set_cls(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 100 && mdw < 10; k++) begin
      #1;
      if (state == 3'd3) mdw++;
      if (mdw < 10) @(negedge clock);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mdw, rf_we} !== {32'd10, 1'b0}) begin
      n_err++; $display("FAIL mid_md_reached: got mdw=%0d rf_we=%b want 10/0", mdw, rf_we);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if ({state, instr_count, rf_we} !== {3'd0, 16'd0, 1'b0}) begin
      n_err++; $display("FAIL mid_md_reset: got state=%0d cnt=%0d rf_we=%b want 0/0/0",
                        state, instr_count, rf_we);
    end
    @(negedge clock);
    reset = 1'b1; run = 1'b0; model_cnt = 16'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({state, ir_en} !== {3'd0, 1'b0}) begin
        n_err++; $display("FAIL run0_hold: got state=%0d ir_en=%b want 0/0", state, ir_en);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_saturation();
    #1;
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    model_cnt = 16'hFFFE;
    @(negedge clock);
    issue("sat_reach", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    issue("sat_hold", 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_halt();
    logic [15:0] cnt0;
    issue("pre_halt", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    cnt0 = instr_count;
    run = 1'b1;
    set_cls(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    #1;
    n_cmp++;
    if ({state, md_start} !== {3'd1, 1'b0}) begin
      n_err++; $display("FAIL halt_decode: got state=%0d md_start=%b want 1/0", state, md_start);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({state, halted, ir_en, pc_en, rf_we, dmem_we, md_start, md_timeout, instr_count}
          !== {3'd6, 1'b1, 6'b0, cnt0}) begin
        n_err++; $display("FAIL halt_hold: cycle %0d got state=%0d halted=%b strobes=%b cnt=%0d want 6/1/0/%0d",
                          k, state, halted, {ir_en, pc_en, rf_we, dmem_we, md_start, md_timeout},
                          instr_count, cnt0);
      end
    end
    set_cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    #1;
    n_cmp++;
    if ({state, halted, instr_count} !== {3'd0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL halt_exit: got state=%0d halted=%b cnt=%0d want 0/0/0",
                        state, halted, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_multdiv();
    test_reset_mid_md();
    test_saturation();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
